multfu_pipe: RTL and testbench
==============================

# multfu_pipe

Parametrised iterative multiply functional unit for the out-of-order core; successor to the fixed 8-bit shift-add multiplier FU. It accepts one issued instruction at a time from the reservation stage and computes a WIDTH×WIDTH product, consuming STEP multiplier bits per cycle. It supports low/high and signed/unsigned result modes. Finished results queue in an OUT_DEPTH-entry result buffer, which decouples compute from CDB/ROB arbitration, and the head entry is presented on the CDB and ROB ports.

## Interface
- WIDTH, 8: operand/result width.
- STEP, 1: multiplier bits consumed per CALC cycle; must divide WIDTH.
- ROBID_W, 4: ROB tag width.
- OUT_DEPTH, 2: result buffer entries, ≥1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_transmit  in  1  issue valid; accepted only when busy=0.
- operand  in  8  opcode; bits[1:0] = mode, other bits ignored.
- depvals  in  [1:0][WIDTH]  [0]=multiplicand a, [1]=multiplier b.
- wbs  in  8  writeback selector, passed through.
- flags  in  8  passed through; flags[7]=1 suppresses CDB broadcast.
- robid  in  ROBID_W  ROB tag.
- cdb_transmit  in  1  CDB grant; the beat completes when cdb_transmit_out=1 in the same cycle.
- cdb_transmit_out  out  1  CDB request.
- cdb_id  out  ROBID_W  head robid.
- cdb_val  out  WIDTH  head result.
- rob_transmit  in  1  ROB grant; the beat completes when rob_transmit_out=1 in the same cycle.
- robid_out, flags_out, wbs_out  out  ROBID_W/8/8  head metadata.
- value_out  out  WIDTH  head result.
- rob_transmit_out  out  1  ROB request.
- busy  out  1  state≠IDLE OR buffer full.

## Operation
- Modes:
  - 00 MUL: low WIDTH bits of the product.
  - 01 MULH: signed×signed, high half.
  - 10 MULHU: unsigned×unsigned, high half.
  - 11 MULHSU: signed a × unsigned b, high half.
- Arithmetic:
  - Latch |a| and |b|, each taken as signed only where the mode says so.
  - Accumulate an unsigned 2·WIDTH-bit product, STEP bits of b per cycle (partial products of |a| shifted).
  - Record neg = sign(a)^sign(b) for the signed operands.
  - In FIX, negate the 2·WIDTH product when neg=1, then select the low or high half.
  - The most negative value (e.g. 0x80) must produce the exact product; magnitude is WIDTH+1-bit safe.
- FSM:
  - IDLE→CALC on accept; latch operands, mode, wbs, flags, robid; clear the accumulator and counter.
  - CALC for N=WIDTH/STEP cycles → FIX.
  - FIX: push the entry into the buffer → IDLE.
- Result buffer:
  - FIFO with per-head cdb_done and rob_done bits.
  - cdb_transmit_out = head valid & ~flags[7] & ~cdb_done.
  - rob_transmit_out = head valid & ~rob_done.
  - Pop when both required beats have completed, counting same-cycle grants. Next entry is presented the following cycle.
  - With flags[7]=1, only the ROB beat is required.
  - Push in FIX always has room: accept requires not-full, and a single engine computes.
  - Simultaneous push and pop are both honoured.
- input_transmit while busy=1 is ignored; no capture, no error.
- Head outputs are valid only while the corresponding request is high. When the buffer is empty, data outputs hold 0.

## Timing
- Accept edge T0; CALC on edges T0+1..T0+N; FIX at T0+N+1; requests visible after edge T0+N+2 (N+2 cycles, 10 for the defaults).
- busy rises the cycle after accept. It falls after FIX when the buffer is not full, so back-to-back issue is possible every N+2 cycles.
- Reset (async, any time): state=IDLE, accumulator, counter and buffer cleared, all outputs 0, busy=0. An in-flight op and buffered results are discarded.
- Grants arriving with no request pending have no effect.

## Test plan
- MUL, a=13, b=11, grants tied high → value_out=cdb_val=0x8F at T0+10, cdb_id=robid; both requests drop the next cycle.
- MULH 0xFD×0x05 (−15=0xFFF1) → 0xFF; MULHSU 0x80×0xFF → 0x80 (−32640=0x8080); MULHU 0xFF×0xFF → 0xFE.
- flags[7]=1 → cdb_transmit_out stays 0; entry pops on the ROB grant alone.
- Grants held low, issue 3 ops → two buffered, busy=1; third issue ignored. Grant CDB and ROB on different cycles → pop only after both; busy falls.
- STEP=4, WIDTH=16: 0x1234×0x5678 MUL → 0x0060 (0x06260060), latency 6.
- rst asserted mid-CALC and with a full buffer → all outputs 0 immediately; the next issue computes correctly.

Source files
------------

// File: rtl/multfu_pipe.sv
// multfu_pipe: iterative shift-add multiply FU with signed/unsigned low/high modes and a result FIFO toward CDB/ROB.
module multfu_pipe #(
  parameter int WIDTH = 8,
  parameter int STEP = 1,
  parameter int ROBID_W = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           input_transmit,
  input  logic [7:0]                     operand,
  input  logic [1:0][WIDTH-1:0]          depvals,
  input  logic [7:0]                     wbs,
  input  logic [7:0]                     flags,
  input  logic [ROBID_W-1:0]             robid,
  input  logic                           cdb_transmit,
  output logic                           cdb_transmit_out,
  output logic [ROBID_W-1:0]             cdb_id,
  output logic [WIDTH-1:0]               cdb_val,
  input  logic                           rob_transmit,
  output logic [ROBID_W-1:0]             robid_out,
  output logic [7:0]                     flags_out,
  output logic [7:0]                     wbs_out,
  output logic [WIDTH-1:0]               value_out,
  output logic                           rob_transmit_out,
  output logic                           busy
);
  localparam int N = WIDTH / STEP;
  localparam int CNW = N > 1 ? $clog2(N) : 1;
  localparam int PW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  typedef struct packed {
    logic [WIDTH-1:0]   val;
    logic [ROBID_W-1:0] id;
    logic [7:0]         fl;
    logic [7:0]         wb;
  } ent_t;
  logic [1:0]         state, mode;
  logic               neg, push_q, cdb_done, rob_done, accept, na, nb, hv, pop;
  logic [2*WIDTH-1:0] acc, a_sh, prod;
  logic [WIDTH-1:0]   b_sh, fix_val;
  logic [CNW-1:0]     cnt;
  logic [7:0]         m_wbs, m_flags;
  logic [ROBID_W-1:0] m_robid;
  logic [PW-1:0]      rd, wr;
  logic [CW-1:0]      count;
  ent_t               mem [OUT_DEPTH];
  ent_t               head;
  logic               unused_ok;
  assign unused_ok = ^operand[7:2];
  assign accept = input_transmit & ~busy;
  assign na = operand[0] & depvals[0][WIDTH-1];
  assign nb = (operand[1:0] == 2'b01) & depvals[1][WIDTH-1];
  assign prod = neg ? -acc : acc;
  assign hv = count != '0;
  assign head = hv ? mem[rd] : '0;
  // a result still in the FIX register occupies a buffer slot for issue purposes
  assign busy = (state != IDLE) | (({1'b0, count} + (CW+1)'(push_q)) >= (CW+1)'(OUT_DEPTH));
  assign cdb_transmit_out = hv & ~head.fl[7] & ~cdb_done;
  assign rob_transmit_out = hv & ~rob_done;
  assign pop = hv & (head.fl[7] | cdb_done | (cdb_transmit & cdb_transmit_out))
                  & (rob_done | (rob_transmit & rob_transmit_out));
  assign cdb_id = head.id;
  assign cdb_val = head.val;
  assign robid_out = head.id;
  assign flags_out = head.fl;
  assign wbs_out = head.wb;
  assign value_out = head.val;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mode <= '0;
      neg <= 1'b0;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      m_wbs <= '0;
      m_flags <= '0;
      m_robid <= '0;
      fix_val <= '0;
      push_q <= 1'b0;
    end else begin
      push_q <= state == FIX;
      if (accept) begin
        state <= CALC;
        mode <= operand[1:0];
        neg <= na ^ nb;
        acc <= '0;
        a_sh <= {{WIDTH{1'b0}}, na ? -depvals[0] : depvals[0]};
        b_sh <= nb ? -depvals[1] : depvals[1];
        cnt <= '0;
        m_wbs <= wbs;
        m_flags <= flags;
        m_robid <= robid;
      end else if (state == CALC) begin
        acc <= acc + a_sh * {{(2*WIDTH-STEP){1'b0}}, b_sh[STEP-1:0]};
        a_sh <= a_sh << STEP;
        b_sh <= b_sh >> STEP;
        cnt <= cnt + 1'b1;
        state <= cnt == CNW'(N-1) ? FIX : CALC;
      end else if (state == FIX) begin
        fix_val <= mode == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        state <= IDLE;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else begin
      if (push_q) wr <= wr == PW'(OUT_DEPTH-1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == PW'(OUT_DEPTH-1) ? '0 : rd + 1'b1;
      count <= count + CW'(push_q) - CW'(pop);
      cdb_done <= ~pop & (cdb_done | (cdb_transmit & cdb_transmit_out));
      rob_done <= ~pop & (rob_done | (rob_transmit & rob_transmit_out));
    end
  always_ff @(posedge clk)
    if (push_q) mem[wr] <= {fix_val, m_robid, m_flags, m_wbs};
endmodule

// File: tb/tb_multfu_pipe.sv
// tb_multfu_pipe: scoreboard bench for multfu_pipe (default 8-bit unit plus a 16-bit STEP=4 instance).
module tb_multfu_pipe;
  logic clk = 0, rst = 1;
  logic it = 0, cg = 0, rg = 0;
  logic [7:0] op = 0, wb = 0, fl = 0;
  logic [1:0][7:0] dv = '0;
  logic [3:0] id = 0;
  logic cdb_req, rob_req, busy;
  logic [3:0] cdb_id, robid_out;
  logic [7:0] cdb_val, value_out, flags_out, wbs_out;
  logic it2 = 0;
  logic [1:0][15:0] dv2 = '0;
  logic cdb_req2, rob_req2, busy2;
  logic [3:0] cdb_id2, robid_out2;
  logic [15:0] cdb_val2, value_out2;
  logic [7:0] flags_out2, wbs_out2;
  typedef struct {logic [7:0] v; logic [3:0] id; logic [7:0] fl; logic [7:0] wb;} exp_t;
  exp_t sb_q[$];
  int d_pass = 0, d_tot = 0, m_pass = 0, m_tot = 0;
  bit cs = 0, rs = 0;
  always #5 clk = ~clk;
  multfu_pipe u1 (.clk(clk), .rst(rst), .input_transmit(it), .operand(op), .depvals(dv), .wbs(wb),
    .flags(fl), .robid(id), .cdb_transmit(cg), .cdb_transmit_out(cdb_req), .cdb_id(cdb_id),
    .cdb_val(cdb_val), .rob_transmit(rg), .robid_out(robid_out), .flags_out(flags_out),
    .wbs_out(wbs_out), .value_out(value_out), .rob_transmit_out(rob_req), .busy(busy));
  multfu_pipe #(.WIDTH(16), .STEP(4)) u2 (.clk(clk), .rst(rst), .input_transmit(it2), .operand(8'h00),
    .depvals(dv2), .wbs(8'h5A), .flags(8'h00), .robid(4'hA), .cdb_transmit(1'b1),
    .cdb_transmit_out(cdb_req2), .cdb_id(cdb_id2), .cdb_val(cdb_val2), .rob_transmit(1'b1),
    .robid_out(robid_out2), .flags_out(flags_out2), .wbs_out(wbs_out2), .value_out(value_out2),
    .rob_transmit_out(rob_req2), .busy(busy2));
  task automatic dchk(string name, logic [31:0] act, logic [31:0] exp);
    d_tot++;
    if (act === exp) d_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic mchk(string name, logic [31:0] act, logic [31:0] exp);
    m_tot++;
    if (act === exp) m_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // monitor: compares each completed CDB/ROB beat against the queue head
  always @(negedge clk) begin
    exp_t e;
    logic cb, rb;
    if (rst) begin
      cs = 0;
      rs = 0;
    end else begin
      cb = cg & cdb_req;
      rb = rg & rob_req;
      if (cb | rb) begin
        if (sb_q.size() == 0) mchk("sb_unexpected_beat", {cb, rb}, 0);
        else begin
          e = sb_q[0];
          if (cb) mchk("sb_cdb", {cdb_val, cdb_id}, {e.v, e.id});
          if (rb) mchk("sb_rob", {value_out, robid_out, flags_out, wbs_out}, {e.v, e.id, e.fl, e.wb});
          cs = cs | cb;
          rs = rs | rb;
          if (rs && (cs || e.fl[7])) begin
            void'(sb_q.pop_front());
            cs = 0;
            rs = 0;
          end
        end
      end
    end
  end
  task automatic issue(logic [7:0] o, logic [7:0] a, logic [7:0] b, logic [3:0] i,
                       logic [7:0] f, logic [7:0] w, logic [7:0] expv);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) dchk("issue_wait", busy, 0);
    it = 1; op = o; dv[0] = a; dv[1] = b; id = i; fl = f; wb = w;
    sb_q.push_back('{v: expv, id: i, fl: f, wb: w});
    @(posedge clk);
    #1 it = 0;
  endtask
  task automatic wait_rob(string name);
    int n = 0;
    while (!rob_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    dchk(name, rob_req, 1);
  endtask
  task automatic do_reset();
    rst = 1;
    sb_q.delete();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
  endtask
  initial begin
    #2 dchk("rst_outs", {busy, rob_req, cdb_req, value_out, cdb_val, robid_out}, 0);
    dchk("rst_outs2", {busy2, rob_req2, value_out2}, 0);
    @(posedge clk);
    #2 rst = 0;
    cg = 1; rg = 1;
    issue(0, 13, 11, 5, 8'h01, 8'h3C, 8'h8F);
    @(negedge clk);
    dchk("busy_rise", busy, 1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dchk("lat_early", {cdb_req, rob_req}, 0);
    dchk("busy_fall", busy, 0);
    @(negedge clk);
    dchk("lat_req", {cdb_req, rob_req}, 2'b11);
    dchk("lat_val", {value_out, cdb_val, cdb_id}, {8'h8F, 8'h8F, 4'd5});
    @(negedge clk);
    dchk("req_drop", {cdb_req, rob_req}, 0);
    issue(1, 8'hFD, 8'h05, 1, 8'h00, 8'h11, 8'hFF);
    issue(3, 8'h80, 8'hFF, 2, 8'h02, 8'h22, 8'h80);
    issue(2, 8'hFF, 8'hFF, 3, 8'h00, 8'h33, 8'hFE);
    issue(0, 8'hFD, 8'h05, 4, 8'h00, 8'h44, 8'hF1);
    repeat (15) @(negedge clk);
    dchk("drain_modes", sb_q.size(), 0);
    rg = 0;
    issue(0, 7, 6, 6, 8'h80, 8'h55, 8'h2A);
    wait_rob("f7_req");
    dchk("f7_no_cdb", cdb_req, 0);
    @(negedge clk);
    dchk("f7_hold", {cdb_req, rob_req}, 2'b01);
    rg = 1;
    @(posedge clk);
    @(negedge clk);
    dchk("f7_pop", rob_req, 0);
    cg = 0; rg = 0;
    issue(0, 5, 5, 7, 8'h00, 8'h66, 8'h19);
    issue(0, 3, 4, 8, 8'h00, 8'h77, 8'h0C);
    repeat (12) @(negedge clk);
    dchk("full_busy", busy, 1);
    dchk("full_head", {value_out, robid_out}, {8'h19, 4'd7});
    it = 1; op = 0; dv[0] = 9; dv[1] = 9; id = 9;
    repeat (5) @(negedge clk);
    dchk("busy_ignore", busy, 1);
    it = 0;
    cg = 1;
    @(posedge clk);
    #1 cg = 0;
    @(negedge clk);
    dchk("cdb_only", {cdb_req, rob_req}, 2'b01);
    dchk("no_pop", value_out, 8'h19);
    rg = 1;
    @(posedge clk);
    #1 rg = 0;
    @(negedge clk);
    dchk("next_head", {value_out, robid_out}, {8'h0C, 4'd8});
    dchk("next_reqs", {cdb_req, rob_req}, 2'b11);
    dchk("busy_drop", busy, 0);
    cg = 1; rg = 1;
    repeat (3) @(negedge clk);
    dchk("third_ignored", {rob_req, 8'(sb_q.size())}, 0);
    @(posedge clk);
    #1 it2 = 1; dv2[0] = 16'h1234; dv2[1] = 16'h5678;
    @(posedge clk);
    #1 it2 = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dchk("w16_early", rob_req2, 0);
    @(negedge clk);
    dchk("w16_req", {cdb_req2, rob_req2}, 2'b11);
    dchk("w16_val", {value_out2, cdb_id2}, {16'h0060, 4'hA});
    cg = 0; rg = 0;
    issue(0, 2, 3, 1, 8'h00, 8'h00, 8'h06);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1 dchk("rst_calc", {busy, rob_req, cdb_req, value_out}, 0);
    do_reset();
    issue(0, 2, 3, 1, 8'h00, 8'h01, 8'h06);
    issue(0, 4, 4, 2, 8'h00, 8'h02, 8'h10);
    repeat (12) @(negedge clk);
    dchk("pre_rst_full", {busy, rob_req, cdb_req}, 3'b111);
    #2 rst = 1;
    #1 dchk("rst_full", {busy, rob_req, cdb_req, value_out, cdb_val, robid_out, cdb_id}, 0);
    dchk("rst_full_meta", {flags_out, wbs_out}, 0);
    do_reset();
    cg = 1; rg = 1;
    issue(1, 8'h80, 8'h80, 4'hB, 8'h01, 8'h99, 8'h40);
    issue(0, 8'h80, 8'h80, 4'hC, 8'h00, 8'h98, 8'h00);
    repeat (15) @(negedge clk);
    dchk("post_rst_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", d_pass + m_pass, d_tot + m_tot);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
